regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised integer register file with a built-in load scoreboard, for the next core revision.
- NUM_RD combinational read ports with write-to-read bypass.
- Two write ports: A for ALU/writeback, B for load return.
- Per-register busy bits let decode stall on load-use and WAW hazards.
- x0 is hardwired to zero and never reports busy.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREGS), register address width (derived, not overridden)
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wa_en  in  1  write port A enable
wa_addr  in  AW  write port A register index
wa_data  in  XLEN  write port A data
wb_en  in  1  write port B (load return) enable; also clears busy
wb_addr  in  AW  write port B register index
wb_data  in  XLEN  write port B data
sb_set  in  1  load issued: mark sb_addr busy
sb_addr  in  AW  destination register of issued load
rd_addr  in  NUM_RD*AW  flattened read indices, port i at [i*AW +: AW]
rd_data  out  NUM_RD*XLEN  flattened read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NUM_RD  port i source register still awaiting load data
busy_vec  out  NREGS  current busy bit per register, bit 0 always 0
wr_collision  out  1  registered pulse: both write ports hit the same nonzero register in the previous cycle

Behaviour:
- Reset, asynchronous on rst_n low:
  - all registers clear to 0; busy_vec clears to 0; wr_collision clears to 0.
  - rd_data therefore reads 0 for every address while in reset.
  - Reset applies immediately mid-operation; writes and sets presented in that cycle are lost.
- Writes, on the rising clk edge:
  - wa_en writes wa_data to wa_addr; wb_en writes wb_data to wb_addr.
  - A write to address 0 is discarded.
  - Both enabled on the same nonzero address: port A data is stored, and wr_collision = 1 in the next cycle, otherwise 0.
  - Both enabled on different addresses: both writes take effect.
- Reads, combinational, zero cycle latency, priority per port i:
  - rd_addr_i == 0 -> 0;
  - else wa_en and wa_addr match -> wa_data;
  - else wb_en and wb_addr match -> wb_data;
  - else stored value.
  - This gives write-first bypass, so a same-cycle writer is visible.
- Scoreboard, on the rising clk edge:
  - sb_set with sb_addr != 0 sets busy[sb_addr].
  - wb_en with wb_addr != 0 clears busy[wb_addr].
  - Set and clear on the same address in the same cycle: set wins, busy stays 1 (a new load issued as the old one returns).
  - sb_set on an already busy register leaves it at 1; no error is flagged, because decode owns WAW stall.
  - wa_en does not affect busy.
- rd_busy_i = busy[rd_addr_i] AND NOT (wb_en AND wb_addr == rd_addr_i).
  - The load return in the current cycle bypasses the stall.
  - rd_busy_i is 0 for address 0.
- busy_vec shows the registered state only, without bypass.
- No X propagation: unused or invalid conditions resolve to defined values.

Decomposition:
- Package regfile_pkg holds:
  - XLEN_DEF, NREGS_DEF, REG_ZERO (index 0);
  - function addr_match(a, b, en), returning en and a==b and a!=REG_ZERO.
- Sub-module regfile_sb_scoreboard (NREGS, AW): holds the busy flops, set/clear priority, busy_vec and per-port rd_busy.
- The top level holds the storage array, the bypass muxes (generate over NUM_RD) and the collision flop.

Test Plan:
1. Reset, then write 32'h12345678 to x1 on port A and 32'h87654321 to x2 on port B in the same cycle; next cycle read x1/x2 -> rd_data = 12345678 / 87654321, wr_collision = 0.
2. wa_en to x0 with data 1 and read x0 on both ports -> rd_data = 0 on both; busy_vec[0] = 0 after sb_set on x0.
3. Same-cycle bypass: wa_en x5 = 32'hDEADBEEF with rd_addr port0 = x5 -> rd_data0 = DEADBEEF in that cycle; port B alone on x6 = 32'hCAFE -> visible in the same cycle.
4. Collision: wa x7 = 32'hA, wb x7 = 32'hB in the same cycle -> x7 reads 32'hA afterwards; wr_collision = 1 for exactly one cycle.
5. Scoreboard sequence:
   - sb_set x3 -> busy_vec[3] = 1 and rd_busy = 1 for reads of x3;
   - wb_en x3 = 32'h55 -> rd_busy = 0 and rd_data = 55 in that cycle, busy clears next edge;
   - sb_set and wb_en on x4 in the same cycle -> busy_vec[4] stays 1.
6. Assert rst_n low asynchronously between edges with busy bits set and registers written -> busy_vec, rd_data and wr_collision go to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and address-match helper for regfile_sb.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;
   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned MATCH_W   = 16;
   localparam logic [MATCH_W-1:0] REG_ZERO = '0;

   // Addresses are widened to MATCH_W by the caller so one helper serves any AW.
   function automatic logic addr_match(input logic [MATCH_W-1:0] a,
                                       input logic [MATCH_W-1:0] b,
                                       input logic               en);
      return en && (a == b) && (a != REG_ZERO);
   endfunction
endpackage

`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
// ============================================================================
// Module      : regfile_sb_scoreboard
// Description : Per-register load busy bits with set-over-clear priority.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_sb_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS  = NREGS_DEF,
   parameter int AW     = $clog2(NREGS),
   parameter int NUM_RD = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wb_en,
   input  logic [AW-1:0]        wb_addr,
   input  logic                 sb_set,
   input  logic [AW-1:0]        sb_addr,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NREGS-1:0]     busy_vec,
   output logic [NUM_RD-1:0]    rd_busy
);
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // A load issued while the previous one returns keeps the register busy.
   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < NREGS; i++) begin
         if (addr_match(MATCH_W'(wb_addr), MATCH_W'(i), wb_en))
            busy_d[i] = 1'b0;
         if (addr_match(MATCH_W'(sb_addr), MATCH_W'(i), sb_set))
            busy_d[i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

   generate
      for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_busy
         logic [AW-1:0] addr;
         assign addr       = rd_addr[p*AW +: AW];
         assign rd_busy[p] = busy_q[addr] &
                             ~addr_match(MATCH_W'(wb_addr), MATCH_W'(addr), wb_en);
      end
   endgenerate
endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : Register file with write-first bypass and load scoreboard.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int AW     = $clog2(NREGS),
   parameter int NUM_RD = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wa_en,
   input  logic [AW-1:0]          wa_addr,
   input  logic [XLEN-1:0]        wa_data,
   input  logic                   wb_en,
   input  logic [AW-1:0]          wb_addr,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   sb_set,
   input  logic [AW-1:0]          sb_addr,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   output logic [NUM_RD-1:0]      rd_busy,
   output logic [NREGS-1:0]       busy_vec,
   output logic                   wr_collision
);
   logic [XLEN-1:0] mem [NREGS];
   logic            wa_hit;
   logic            wb_hit;

   assign wa_hit = addr_match(MATCH_W'(wa_addr), MATCH_W'(wa_addr), wa_en);
   assign wb_hit = addr_match(MATCH_W'(wb_addr), MATCH_W'(wb_addr), wb_en);

   // Port A is written last so it wins a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
         wr_collision <= 1'b0;
      end else begin
         if (wb_hit) mem[wb_addr] <= wb_data;
         if (wa_hit) mem[wa_addr] <= wa_data;
         wr_collision <= addr_match(MATCH_W'(wa_addr), MATCH_W'(wb_addr), wa_en & wb_en);
      end
   end

   generate
      for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
         logic [AW-1:0] addr;
         assign addr = rd_addr[p*AW +: AW];
         always_comb begin
            rd_data[p*XLEN +: XLEN] = mem[addr];
            if (addr_match(MATCH_W'(wb_addr), MATCH_W'(addr), wb_en))
               rd_data[p*XLEN +: XLEN] = wb_data;
            if (addr_match(MATCH_W'(wa_addr), MATCH_W'(addr), wa_en))
               rd_data[p*XLEN +: XLEN] = wa_data;
            if (addr == AW'(0))
               rd_data[p*XLEN +: XLEN] = '0;
         end
      end
   endgenerate

   regfile_sb_scoreboard #(
      .NREGS  (NREGS),
      .AW     (AW),
      .NUM_RD (NUM_RD)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .sb_set   (sb_set),
      .sb_addr  (sb_addr),
      .rd_addr  (rd_addr),
      .busy_vec (busy_vec),
      .rd_busy  (rd_busy)
   );
endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module      : tb_regfile_sb
// Description : Randomised and directed bench for regfile_sb against a model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sb;
   localparam int XLEN = 32, NREGS = 32, AW = 5, NUM_RD = 2;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   wa_en, wb_en, sb_set;
   logic [AW-1:0]          wa_addr, wb_addr, sb_addr;
   logic [XLEN-1:0]        wa_data, wb_data;
   logic [NUM_RD*AW-1:0]   rd_addr;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]      rd_busy;
   logic [NREGS-1:0]       busy_vec;
   logic                   wr_collision;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: architectural values, pending loads, collision pulse.
   logic [XLEN-1:0] m_reg [NREGS];
   bit              m_busy [NREGS];
   bit              m_col;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_RD(NUM_RD)) dut (
      .clk(clk), .rst_n(rst_n),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .sb_set(sb_set), .sb_addr(sb_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .busy_vec(busy_vec), .wr_collision(wr_collision)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] exp_read(input int a);
      if (a == 0)                                        return '0;
      if (wa_en && int'(wa_addr) == a)                   return wa_data;
      if (wb_en && int'(wb_addr) == a)                   return wb_data;
      return m_reg[a];
   endfunction

   function automatic bit exp_rbusy(input int a);
      return a != 0 && m_busy[a] && !(wb_en && int'(wb_addr) == a);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
         m_col = 0;
      end else begin
         m_col = wa_en && wb_en && wa_addr == wb_addr && wa_addr != 0;
         if (wb_en && wb_addr != 0) begin m_reg[wb_addr] = wb_data; m_busy[wb_addr] = 0; end
         if (wa_en && wa_addr != 0) m_reg[wa_addr] = wa_data;
         if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1;
      end
   end

   always @(negedge clk) begin
      logic [NREGS-1:0] ev;
      for (int i = 0; i < NREGS; i++) ev[i] = m_busy[i];
      chk("busy_vec", 64'(busy_vec), 64'(ev));
      chk("wr_collision", 64'(wr_collision), 64'(m_col));
      for (int p = 0; p < NUM_RD; p++) begin
         int a;
         a = int'(rd_addr[p*AW +: AW]);
         chk($sformatf("rd_data%0d", p), 64'(rd_data[p*XLEN +: XLEN]), 64'(exp_read(a)));
         chk($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(exp_rbusy(a)));
      end
   end

   task automatic idle();
      wa_en = 0; wb_en = 0; sb_set = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic rd(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   initial begin
      rst_n = 0; idle();
      wa_addr = '0; wb_addr = '0; sb_addr = '0; wa_data = '0; wb_data = '0; rd_addr = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      rd(1, 2); #1;
      chk("reset rd_data", 64'(rd_data), 64'h0);
      chk("reset busy_vec", 64'(busy_vec), 64'h0);
      chk("reset wr_collision", 64'(wr_collision), 64'h0);

      // Parallel writes to two different registers.
      wa_en = 1; wa_addr = 1; wa_data = 32'h12345678;
      wb_en = 1; wb_addr = 2; wb_data = 32'h87654321;
      step(); idle(); #1;
      chk("x1/x2 read", 64'(rd_data), 64'h87654321_12345678);
      chk("no collision", 64'(wr_collision), 64'h0);

      // x0 is never written nor busy.
      wa_en = 1; wa_addr = 0; wa_data = 32'h1; sb_set = 1; sb_addr = 0; rd(0, 0); #1;
      chk("x0 bypass", 64'(rd_data), 64'h0);
      step(); idle(); #1;
      chk("x0 read", 64'(rd_data), 64'h0);
      chk("x0 busy", 64'(busy_vec[0]), 64'h0);

      // Same-cycle bypass from each write port.
      wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; rd(5, 1); #1;
      chk("bypass A", 64'(rd_data[31:0]), 64'hDEADBEEF);
      step(); idle();
      wb_en = 1; wb_addr = 6; wb_data = 32'hCAFE; rd(6, 5); #1;
      chk("bypass B", 64'(rd_data), 64'hDEADBEEF_0000CAFE);
      step(); idle();

      // Collision: A wins and the flag pulses for one cycle.
      wa_en = 1; wa_addr = 7; wa_data = 32'hA; wb_en = 1; wb_addr = 7; wb_data = 32'hB;
      step(); idle(); rd(7, 7); #1;
      chk("collision data", 64'(rd_data[31:0]), 64'hA);
      chk("collision pulse", 64'(wr_collision), 64'h1);
      step(); #1;
      chk("collision cleared", 64'(wr_collision), 64'h0);

      // Scoreboard: set, bypassed return, set-over-clear.
      sb_set = 1; sb_addr = 3; step(); idle(); rd(3, 3); #1;
      chk("x3 busy", 64'(busy_vec[3]), 64'h1);
      chk("x3 rd_busy", 64'(rd_busy), 64'h3);
      wb_en = 1; wb_addr = 3; wb_data = 32'h55; #1;
      chk("x3 return rd_busy", 64'(rd_busy), 64'h0);
      chk("x3 return data", 64'(rd_data[31:0]), 64'h55);
      step(); idle(); #1;
      chk("x3 cleared", 64'(busy_vec[3]), 64'h0);
      sb_set = 1; sb_addr = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h9;
      step(); idle(); #1;
      chk("x4 set wins", 64'(busy_vec[4]), 64'h1);

      // Random traffic, biased to low addresses for frequent hazards.
      for (int n = 0; n < 3000; n++) begin
         int hi;
         hi = ($urandom_range(0, 3) == 0) ? NREGS - 1 : 7;
         wa_en   = $urandom_range(0, 1) == 1;
         wb_en   = $urandom_range(0, 2) == 0;
         sb_set  = $urandom_range(0, 2) == 0;
         wa_addr = AW'($urandom_range(0, hi));
         wb_addr = AW'($urandom_range(0, hi));
         sb_addr = AW'($urandom_range(0, hi));
         wa_data = $urandom;
         wb_data = $urandom;
         rd($urandom_range(0, hi), $urandom_range(0, hi));
         step();
      end
      idle();

      // Asynchronous reset between edges wipes all visible state.
      sb_set = 1; sb_addr = 9; wa_en = 1; wa_addr = 10; wa_data = 32'h77; wb_en = 1;
      wb_addr = 10; wb_data = 32'h88;
      step(); idle(); rd(10, 9); #1;
      chk("pre-reset data", 64'(rd_data[31:0]), 64'h77);
      chk("pre-reset collision", 64'(wr_collision), 64'h1);
      rst_n = 0; #1;
      chk("async rd_data", 64'(rd_data), 64'h0);
      chk("async busy_vec", 64'(busy_vec), 64'h0);
      chk("async wr_collision", 64'(wr_collision), 64'h0);
      step(); rst_n = 1; step(); step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
